// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, FSM state encoding and helpers for the pipe_ctrl hazard/flush controller.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_LEN     = 5;
  localparam int WIDTH            = 16;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register 2-bit pending-write counters with two read-port lookups and an all-empty flag.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc_en,
  input  logic [ADDR_W-1:0] i_inc_addr,
  input  logic              i_dec_en,
  input  logic [ADDR_W-1:0] i_dec_addr,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [1:0]        o_rs_cnt,
  output logic [1:0]        o_rt_cnt,
  output logic              o_all_empty
);

  localparam int NREG = 1 << ADDR_W;

  logic [1:0]      r_pend [NREG];
  logic [NREG-1:0] w_inc;
  logic [NREG-1:0] w_dec;
  logic [NREG-1:0] w_busy;

  // Register 0 is excluded from every decode, so its counter stays at its reset value.
  always_comb begin
    w_inc  = '0;
    w_dec  = '0;
    w_busy = '0;
    for (int i = 1; i < NREG; i++) begin
      w_inc[i]  = i_inc_en && (i_inc_addr == ADDR_W'(i));
      w_dec[i]  = i_dec_en && (i_dec_addr == ADDR_W'(i));
      w_busy[i] = (r_pend[i] != 2'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= 2'd0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_pend[i] != 2'd3))
          r_pend[i] <= r_pend[i] + 2'd1;
        else if (w_dec[i] && !w_inc[i] && (r_pend[i] != 2'd0))
          r_pend[i] <= r_pend[i] - 2'd1;
      end
    end
  end

  assign o_rs_cnt    = r_pend[i_rs_addr];
  assign o_rt_cnt    = r_pend[i_rt_addr];
  assign o_all_empty = ~|w_busy;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/halt controller with a register-pending scoreboard.
// Optional write-through bypass of retiring registers: define PIPE_CTRL_FWD_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int REG_ADDR_LEN = pipe_ctrl_pkg::REG_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_rs_addr,
  input  logic [REG_ADDR_LEN-1:0] id_rt_addr,
  input  logic                    id_rs_used,
  input  logic                    id_rt_used,
  input  logic                    id_wr_en,
  input  logic [REG_ADDR_LEN-1:0] id_rd_addr,
  input  logic                    id_halt,
  input  logic                    ex_branch_taken,
  input  logic                    wb_wr_en,
  input  logic [REG_ADDR_LEN-1:0] wb_wr_addr,
  output logic                    IsStall,
  output logic                    IsFlush,
  output logic                    halted,
  output logic [WIDTH-1:0]        stall_cnt
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_flush_cnt;
  logic [1:0]       w_flush_nxt;
  logic [WIDTH-1:0] r_stall_cnt;

  logic [1:0] w_rs_cnt;
  logic [1:0] w_rt_cnt;
  logic       w_all_empty;
  logic       w_rs_byp;
  logic       w_rt_byp;
  logic       w_hazard;
  logic       w_issue;
  logic       w_inc_en;

  pipe_scoreboard #(
    .ADDR_W(REG_ADDR_LEN)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_inc_en   (w_inc_en),
    .i_inc_addr (id_rd_addr),
    .i_dec_en   (wb_wr_en),
    .i_dec_addr (wb_wr_addr),
    .i_rs_addr  (id_rs_addr),
    .i_rt_addr  (id_rt_addr),
    .o_rs_cnt   (w_rs_cnt),
    .o_rt_cnt   (w_rt_cnt),
    .o_all_empty(w_all_empty)
  );

`ifdef PIPE_CTRL_FWD_EN
  // A last outstanding write retiring this cycle can be bypassed to the reader.
  assign w_rs_byp = (w_rs_cnt == 2'd1) && wb_wr_en && (wb_wr_addr == id_rs_addr);
  assign w_rt_byp = (w_rt_cnt == 2'd1) && wb_wr_en && (wb_wr_addr == id_rt_addr);
`else
  assign w_rs_byp = 1'b0;
  assign w_rt_byp = 1'b0;
`endif

  assign w_hazard = id_valid &&
                    ((id_rs_used && (w_rs_cnt != 2'd0) && !w_rs_byp) ||
                     (id_rt_used && (w_rt_cnt != 2'd0) && !w_rt_byp));

  // Same as id_valid & ~IsStall & ~IsFlush & RUN, written without reading the outputs back.
  assign w_issue  = (r_state == ST_RUN) && id_valid && !(w_hazard && !ex_branch_taken);
  assign w_inc_en = w_issue && id_wr_en && (id_rd_addr != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    IsStall     = 1'b0;
    IsFlush     = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_RUN: begin
        IsStall = w_hazard && !ex_branch_taken;
        if (ex_branch_taken) begin
          w_state_nxt = ST_FLUSH;
          w_flush_nxt = FLUSH_LOAD;
        end else if (w_issue && id_halt) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        IsFlush = 1'b1;
        if (ex_branch_taken) begin
          w_flush_nxt = FLUSH_LOAD;
        end else if (r_flush_cnt > 2'd1) begin
          w_flush_nxt = r_flush_cnt - 2'd1;
        end else begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = 2'd0;
        end
      end
      ST_DRAIN: begin
        IsStall = 1'b1;
        if (ex_branch_taken) begin
          w_state_nxt = ST_FLUSH;
          w_flush_nxt = FLUSH_LOAD;
        end else if (w_all_empty) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        IsStall = 1'b1;
        halted  = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 2'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      if (IsStall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table of per-cycle vectors plus hand-written reset/drain/flush sequences.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt;
  logic [4:0] id_rs_addr, id_rt_addr, id_rd_addr, wb_wr_addr;
  logic       ex_branch_taken, wb_wr_en;
  logic       IsStall, IsFlush, halted;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  pipe_ctrl #(.FLUSH_CYCLES(2), .REG_ADDR_LEN(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs_addr     (id_rs_addr),
    .id_rt_addr     (id_rt_addr),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .id_wr_en       (id_wr_en),
    .id_rd_addr     (id_rd_addr),
    .id_halt        (id_halt),
    .ex_branch_taken(ex_branch_taken),
    .wb_wr_en       (wb_wr_en),
    .wb_wr_addr     (wb_wr_addr),
    .IsStall        (IsStall),
    .IsFlush        (IsFlush),
    .halted         (halted),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic       wr;
    logic [4:0] rd;
    logic       halt;
    logic       br;
    logic       wbe;
    logic [4:0] wba;
    logic       e_stall;
    logic       e_flush;
    logic       e_halted;
    int         e_cnt;
  } vec_t;

  typedef struct packed {
    logic        s;
    logic        f;
    logic        h;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t V(logic valid, int rs, logic rsu, int rt, logic rtu, logic wr, int rd,
                             logic halt, logic br, logic wbe, int wba,
                             logic es, logic ef, logic eh, int ec);
    vec_t v;
    v.valid = valid; v.rs = 5'(rs); v.rsu = rsu; v.rt = 5'(rt); v.rtu = rtu;
    v.wr = wr; v.rd = 5'(rd); v.halt = halt; v.br = br; v.wbe = wbe; v.wba = 5'(wba);
    v.e_stall = es; v.e_flush = ef; v.e_halted = eh; v.e_cnt = ec;
    return v;
  endfunction

  function automatic vec_t I(logic es, logic ef, logic eh, int ec);
    return V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, es, ef, eh, ec);
  endfunction
  function automatic vec_t W(int rd, logic es, logic ef, logic eh, int ec);
    return V(1, 0, 0, 0, 0, 1, rd, 0, 0, 0, 0, es, ef, eh, ec);
  endfunction
  function automatic vec_t R(int rs, logic es, logic ef, logic eh, int ec);
    return V(1, rs, 1, 0, 0, 0, 0, 0, 0, 0, 0, es, ef, eh, ec);
  endfunction
  function automatic vec_t B(int a, logic es, logic ef, logic eh, int ec);
    return V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, a, es, ef, eh, ec);
  endfunction
  function automatic vec_t H(logic br, logic es, logic ef, logic eh, int ec);
    return V(1, 0, 0, 0, 0, 0, 0, 1, br, 0, 0, es, ef, eh, ec);
  endfunction

  task automatic drive_idle();
    id_valid = 0; id_rs_addr = 0; id_rs_used = 0; id_rt_addr = 0; id_rt_used = 0;
    id_wr_en = 0; id_rd_addr = 0; id_halt = 0; ex_branch_taken = 0;
    wb_wr_en = 0; wb_wr_addr = 0;
  endtask

  task automatic compare(input int id);
    exp_t e, got;
    got = {IsStall, IsFlush, halted, stall_cnt};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL step%0d: got stall=%b flush=%b halted=%b cnt=%0d, want stall=%b flush=%b halted=%b cnt=%0d",
               id, got.s, got.f, got.h, got.c, e.s, e.f, e.h, e.c);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    id_valid = v.valid; id_rs_addr = v.rs; id_rs_used = v.rsu; id_rt_addr = v.rt; id_rt_used = v.rtu;
    id_wr_en = v.wr; id_rd_addr = v.rd; id_halt = v.halt; ex_branch_taken = v.br;
    wb_wr_en = v.wbe; wb_wr_addr = v.wba;
    exp_q.push_back({v.e_stall, v.e_flush, v.e_halted, 16'(v.e_cnt)});
    #1;
    compare(id);
  endtask

  // Asserted mid-cycle so the asynchronous path is what clears the outputs.
  task automatic do_reset(input int id);
    drive_idle();
    #2;
    rst = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'd0});
    #1;
    compare(id);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    do_reset(900);

    // Hazard on r5 until its write retires; stall_cnt counts the stalled cycles.
    tbl.push_back(I(0, 0, 0, 0));
    tbl.push_back(W(5, 0, 0, 0, 0));
    tbl.push_back(R(5, 1, 0, 0, 0));
    tbl.push_back(R(5, 1, 0, 0, 1));
    tbl.push_back(B(5, 0, 0, 0, 2));
    tbl.push_back(R(5, 0, 0, 0, 2));
    // Two writes to r3 in flight, retired one at a time.
    tbl.push_back(W(3, 0, 0, 0, 2));
    tbl.push_back(W(3, 0, 0, 0, 2));
    tbl.push_back(V(1, 0, 0, 3, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 2));
    tbl.push_back(V(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3));
    tbl.push_back(B(3, 0, 0, 0, 4));
    tbl.push_back(V(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    // r0 never pending; unused sources ignored; retire of an idle register does not underflow.
    tbl.push_back(W(0, 0, 0, 0, 4));
    tbl.push_back(V(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(W(6, 0, 0, 0, 4));
    tbl.push_back(V(1, 6, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(B(6, 0, 0, 0, 4));
    tbl.push_back(B(9, 0, 0, 0, 4));
    tbl.push_back(R(9, 0, 0, 0, 4));
    // Taken branch: exactly two flush cycles, writer in ID during flush is not issued.
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4));
    tbl.push_back(W(4, 0, 1, 0, 4));
    tbl.push_back(W(4, 0, 1, 0, 4));
    tbl.push_back(R(4, 0, 0, 0, 4));
    // Branch beats hazard; a second branch during flush reloads the flush counter.
    tbl.push_back(W(8, 0, 0, 0, 4));
    tbl.push_back(V(1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4));
    tbl.push_back(R(8, 0, 1, 0, 4));
    tbl.push_back(V(1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 4));
    tbl.push_back(R(8, 0, 1, 0, 4));
    tbl.push_back(R(8, 0, 1, 0, 4));
    tbl.push_back(R(8, 1, 0, 0, 4));
    tbl.push_back(B(8, 0, 0, 0, 5));
    tbl.push_back(R(8, 0, 0, 0, 5));
    // Reader of r9 while its only write retires: bypassed only when forwarding is built in.
    tbl.push_back(W(9, 0, 0, 0, 5));
    tbl.push_back(V(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 9, !FWD, 0, 0, 5));
    tbl.push_back(R(9, 0, 0, 0, FWD ? 5 : 6));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

    // HALT with r7 pending: drain, halt once empty, stay halted until reset.
    do_reset(901);
    apply(W(7, 0, 0, 0, 0), 200);
    apply(H(0, 0, 0, 0, 0), 201);
    apply(I(1, 0, 0, 0), 202);
    apply(B(7, 1, 0, 0, 1), 203);
    apply(I(1, 0, 0, 2), 204);
    apply(I(1, 0, 1, 3), 205);
    apply(V(1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 4), 206);
    do_reset(902);
    apply(I(0, 0, 0, 0), 207);

    // Reset in the middle of a flush discards the pending r10 write.
    apply(W(10, 0, 0, 0, 0), 300);
    apply(V(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 301);
    apply(I(0, 1, 0, 0), 302);
    do_reset(903);
    apply(R(10, 0, 0, 0, 0), 303);

    // Reset in the middle of a drain.
    apply(W(11, 0, 0, 0, 0), 400);
    apply(H(0, 0, 0, 0, 0), 401);
    apply(I(1, 0, 0, 0), 402);
    do_reset(904);
    apply(R(11, 0, 0, 0, 0), 403);
    apply(I(0, 0, 0, 0), 404);

    // Branch during drain squashes the HALT; branch beats HALT in RUN.
    apply(W(12, 0, 0, 0, 0), 500);
    apply(H(0, 0, 0, 0, 0), 501);
    apply(V(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), 502);
    apply(I(0, 1, 0, 1), 503);
    apply(I(0, 1, 0, 1), 504);
    apply(R(12, 1, 0, 0, 1), 505);
    apply(B(12, 0, 0, 0, 2), 506);
    apply(R(12, 0, 0, 0, 2), 507);
    apply(H(1, 0, 0, 0, 2), 508);
    apply(I(0, 1, 0, 2), 509);
    apply(I(0, 1, 0, 2), 510);
    apply(I(0, 0, 0, 2), 511);

    // Pending counter saturates at 3 rather than wrapping.
    do_reset(905);
    for (int k = 0; k < 4; k++) apply(W(13, 0, 0, 0, 0), 600 + k);
    apply(R(13, 1, 0, 0, 0), 604);
    for (int k = 0; k < 3; k++) apply(B(13, 0, 0, 0, 1), 605 + k);
    apply(R(13, 0, 0, 0, 1), 608);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
